// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
// Optional forwarding outputs are enabled by defining REGWB_BYPASS_EN.
package regfile_wb_pkg;

  localparam int unsigned NREGS_DEF = 16;
  localparam int unsigned AW_DEF    = 4;
  localparam int unsigned DW_DEF    = 32;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_ALU = 1'b1
  } src_e;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_req_t;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_MEM) ? SRC_ALU : SRC_MEM;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a pointer
// that always moves to the source that was not granted.
module rr_arb2
  import regfile_wb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_req_i,
  input  logic alu_req_i,
  output logic mem_gnt_o,
  output logic alu_gnt_o
);

  src_e ptr_q, ptr_d;

  always_comb begin
    mem_gnt_o = 1'b0;
    alu_gnt_o = 1'b0;
    if (mem_req_i && alu_req_i) begin
      if (ptr_q == SRC_MEM) begin
        mem_gnt_o = 1'b1;
      end else begin
        alu_gnt_o = 1'b1;
      end
    end else begin
      mem_gnt_o = mem_req_i;
      alu_gnt_o = alu_req_i;
    end

    // Even an uncontested grant hands priority to the other source.
    ptr_d = ptr_q;
    if (mem_gnt_o) begin
      ptr_d = other_src(SRC_MEM);
    end else if (alu_gnt_o) begin
      ptr_d = other_src(SRC_ALU);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= SRC_MEM;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback and keeps
// a per-register busy scoreboard for hazard stalls. Optional: REGWB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_addr,
  input  logic [DW-1:0]    alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_data,
  output logic [AW-1:0]    WriteReg,
  output logic [DW-1:0]    WriteData,
  output logic             RegWrite,
  input  logic             claim_valid,
  input  logic [AW-1:0]    claim_addr,
  input  logic [AW-1:0]    chk_a1,
  input  logic [AW-1:0]    chk_a2,
  output logic             stall,
  output logic [NREGS-1:0] busy,
`ifdef REGWB_BYPASS_EN
  output logic             fwd1_en,
  output logic             fwd2_en,
  output logic [DW-1:0]    fwd1_data,
  output logic [DW-1:0]    fwd2_data,
`endif
  output logic             claim_err
);

  logic mem_gnt, alu_gnt;

  rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .mem_req_i (mem_valid),
    .alu_req_i (alu_valid),
    .mem_gnt_o (mem_gnt),
    .alu_gnt_o (alu_gnt)
  );

  assign mem_ready = mem_gnt;
  assign alu_ready = alu_gnt;

  // Write stage
  wb_req_t wr_q, wr_d;
  logic    wr_en_q, wr_en_d;

  always_comb begin
    wr_d    = wr_q;
    wr_en_d = 1'b0;
    if (alu_gnt) begin
      wr_d.addr = alu_addr;
      wr_d.data = alu_data;
      wr_en_d   = 1'b1;
    end else if (mem_gnt) begin
      wr_d.addr = mem_addr;
      wr_d.data = mem_data;
      wr_en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign WriteReg  = wr_q.addr;
  assign WriteData = wr_q.data;
  assign RegWrite  = wr_en_q;

  // Scoreboard
  logic [NREGS-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic             claim_err_q, claim_err_d;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (claim_valid) begin
      set_vec[claim_addr] = 1'b1;
    end
    if (wr_en_q) begin
      clr_vec[wr_q.addr] = 1'b1;
    end
    // Set applied after clear so a fresh claim survives a same-cycle retire.
    busy_d      = (busy_q & ~clr_vec) | set_vec;
    claim_err_d = claim_err_q |
                  (claim_valid & busy_q[claim_addr] & ~clr_vec[claim_addr]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign busy      = busy_q;
  assign claim_err = claim_err_q;

`ifdef REGWB_BYPASS_EN
  always_comb begin
    fwd1_en   = wr_en_q && (wr_q.addr == chk_a1);
    fwd2_en   = wr_en_q && (wr_q.addr == chk_a2);
    fwd1_data = wr_q.data;
    fwd2_data = wr_q.data;
    stall     = (busy_q[chk_a1] & ~fwd1_en) | (busy_q[chk_a2] & ~fwd2_en);
  end
`else
  assign stall = busy_q[chk_a1] | busy_q[chk_a2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, arbitration order, write
// latency, scoreboard set/clear priority, sticky claim error and mid-run reset.
module tb_regfile_wb_arbiter;
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0]    alu_addr, mem_addr, WriteReg, claim_addr, chk_a1, chk_a2;
  logic [DW-1:0]    alu_data, mem_data, WriteData;
  logic             RegWrite, claim_valid, stall, claim_err;
  logic [NREGS-1:0] busy;
`ifdef REGWB_BYPASS_EN
  logic             fwd1_en, fwd2_en;
  logic [DW-1:0]    fwd1_data, fwd2_data;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  regfile_wb_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .RegWrite    (RegWrite),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .chk_a1      (chk_a1),
    .chk_a2      (chk_a2),
    .stall       (stall),
    .busy        (busy),
`ifdef REGWB_BYPASS_EN
    .fwd1_en     (fwd1_en),
    .fwd2_en     (fwd2_en),
    .fwd1_data   (fwd1_data),
    .fwd2_data   (fwd2_data),
`endif
    .claim_err   (claim_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    alu_valid   = 1'b1;
    mem_valid   = 1'b1;
    alu_addr    = AW'($urandom);
    mem_addr    = AW'($urandom);
    alu_data    = $urandom;
    mem_data    = $urandom;
    claim_valid = 1'b1;
    claim_addr  = AW'($urandom);
    chk_a1      = '0;
    chk_a2      = '0;

    // Reset held with live inputs
    step();
    step();
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_writereg", 64'(WriteReg), 64'd0);
    check("rst_writedata", 64'(WriteData), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_claim_err", 64'(claim_err), 64'd0);
    check("rst_both_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_both_alu_ready", 64'(alu_ready), 64'd0);
    mem_valid = 1'b0;
    #1;
    check("rst_alu_only_ready", 64'(alu_ready), 64'd1);
    check("rst_alu_only_mem_ready", 64'(mem_ready), 64'd0);

    alu_valid   = 1'b0;
    claim_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    // ALU-only writeback
    alu_valid = 1'b1;
    alu_addr  = 4'd2;
    alu_data  = 32'h0000_000F;
    #1;
    check("alu_only_ready", 64'(alu_ready), 64'd1);
    check("alu_only_mem_ready", 64'(mem_ready), 64'd0);
    step();
    alu_valid = 1'b0;
    check("alu_only_regwrite", 64'(RegWrite), 64'd1);
    check("alu_only_writereg", 64'(WriteReg), 64'd2);
    check("alu_only_writedata", 64'(WriteData), 64'h0F);
    step();
    check("idle_regwrite", 64'(RegWrite), 64'd0);

    // Contested: pointer is back at MEM after the ALU grant
    alu_valid = 1'b1;
    alu_addr  = 4'd3;
    alu_data  = 32'h33;
    mem_valid = 1'b1;
    mem_addr  = 4'd5;
    mem_data  = 32'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("dual%0d_mem_ready", i), 64'(mem_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("dual%0d_alu_ready", i), 64'(alu_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
      step();
      if (i == 3) begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
      end
      check($sformatf("dual%0d_regwrite", i), 64'(RegWrite), 64'd1);
      check($sformatf("dual%0d_writereg", i), 64'(WriteReg), (i % 2 == 0) ? 64'd5 : 64'd3);
      check($sformatf("dual%0d_writedata", i), 64'(WriteData),
            (i % 2 == 0) ? 64'h55 : 64'h33);
    end
    step();
    check("dual_end_regwrite", 64'(RegWrite), 64'd0);
    check("write_nonbusy_busy", 64'(busy), 64'd0);

    // Claim r7 then retire it from the ALU
    claim_valid = 1'b1;
    claim_addr  = 4'd7;
    step();
    claim_valid = 1'b0;
    chk_a1      = 4'd7;
    chk_a2      = 4'd0;
    #1;
    check("claim7_busy", 64'(busy), 64'h80);
    check("claim7_stall", 64'(stall), 64'd1);
    alu_valid = 1'b1;
    alu_addr  = 4'd7;
    alu_data  = 32'h77;
    step();
    alu_valid = 1'b0;
    check("wr7_regwrite", 64'(RegWrite), 64'd1);
`ifdef REGWB_BYPASS_EN
    check("wr7_stall_bypass", 64'(stall), 64'd0);
    check("wr7_fwd1_en", 64'(fwd1_en), 64'd1);
    check("wr7_fwd1_data", 64'(fwd1_data), 64'h77);
`else
    check("wr7_stall", 64'(stall), 64'd1);
`endif
    step();
    check("after7_busy", 64'(busy), 64'd0);
    check("after7_stall", 64'(stall), 64'd0);

    // chk_a2 path
    chk_a1      = 4'd0;
    chk_a2      = 4'd9;
    claim_valid = 1'b1;
    claim_addr  = 4'd9;
    step();
    claim_valid = 1'b0;
    check("claim9_stall_a2", 64'(stall), 64'd1);

    // Same-cycle claim and retire of r4: set wins, no error
    claim_valid = 1'b1;
    claim_addr  = 4'd4;
    step();
    claim_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_addr    = 4'd4;
    alu_data    = 32'h44;
    step();
    alu_valid   = 1'b0;
    claim_valid = 1'b1;
    claim_addr  = 4'd4;
    check("wr4_regwrite", 64'(RegWrite), 64'd1);
    step();
    claim_valid = 1'b0;
    check("claim_clr4_busy", 64'(busy), 64'h0210);
    check("claim_clr4_err", 64'(claim_err), 64'd0);
    claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    check("reclaim4_err", 64'(claim_err), 64'd1);
    check("reclaim4_busy", 64'(busy), 64'h0210);
    step();
    step();
    check("reclaim4_err_sticky", 64'(claim_err), 64'd1);

    // Reset mid-stream; pointer moves to ALU after the MEM grant here
    chk_a1    = 4'd4;
    alu_valid = 1'b1;
    alu_addr  = 4'd3;
    alu_data  = 32'h33;
    mem_valid = 1'b1;
    mem_addr  = 4'd5;
    mem_data  = 32'h55;
    step();
    #1;
    check("pre_rst_alu_ready", 64'(alu_ready), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_regwrite", 64'(RegWrite), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_claim_err", 64'(claim_err), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_mem_ready", 64'(mem_ready), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
    step();
    check("post_rst_writereg", 64'(WriteReg), 64'd5);
    check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: ALU results and memory load data. Arbitration is round-robin.
Also keeps a per-register busy scoreboard. Decode claims a destination register at issue, and the block raises a hazard stall when a source operand is still pending.
Sits between execute/memory stages and the RegisterFile write port (WriteReg, data, RegWrite).

Parameters:
NREGS, 16, number of architectural registers
AW, 4, register address width (log2 NREGS)
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
WriteReg  out  AW  register file write address
WriteData  out  DW  register file write data (drives RegisterFile ALUResult)
RegWrite  out  1  register file write enable
claim_valid  in  1  decode issues an instruction writing claim_addr
claim_addr  in  AW  register being claimed
chk_a1  in  AW  source operand 1 to check
chk_a2  in  AW  source operand 2 to check
stall  out  1  hazard: a checked source is busy
busy  out  NREGS  scoreboard vector
claim_err  out  1  sticky: a register was claimed while already busy

Behaviour:
- Reset (rst=0, async): RegWrite=0, WriteReg=0, WriteData=0, busy=0, claim_err=0, priority pointer=MEM.
- Handshake: a request transfers when valid && ready.
  - ready is combinational from both valids and the pointer.
  - At most one ready is high per cycle.
  - Requesters hold valid/addr/data stable until ready.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: the pointer owner is granted; the pointer then flips to the other source.
  - A single uncontested grant also sets the pointer to the other source.
  - Continuous dual requests therefore alternate MEM, ALU, MEM, ...
- Write stage: the granted addr/data are registered. RegWrite=1 exactly one cycle after acceptance (latency 1); RegWrite=0 when nothing was accepted. Throughput is one write per cycle.
- Scoreboard:
  - claim_valid sets busy[claim_addr] at the clock edge.
  - A RegWrite=1 cycle clears busy[WriteReg] at that edge.
  - Claim and clear of the same register in the same cycle: the set wins (new producer pending).
  - Claim of an already-busy register, with no same-cycle clear: set claim_err (sticky until reset); busy stays 1.
  - Write to a non-busy register: allowed; busy stays 0.
- stall = busy[chk_a1] | busy[chk_a2], combinational. It does not account for a clear landing at the current edge.
- Reset mid-operation: all state clears immediately, and in-flight registered writes are discarded (RegWrite forced 0).

Optional Feature:
REGWB_BYPASS_EN.
- Defined:
  - Adds ports fwd1_en, fwd2_en (out 1) and fwd1_data, fwd2_data (out DW).
  - When RegWrite=1 and WriteReg==chk_aN: fwd N_en=1, fwd N_data=WriteData, and that operand does not contribute to stall.
- Undefined: the ports are absent and stall is as specified above.

Decomposition:
- Package regfile_wb_pkg holds:
  - parameter defaults NREGS/AW/DW;
  - enum src_e {SRC_MEM, SRC_ALU} for the pointer and grant;
  - struct wb_req_t {addr, data}.
- One sub-module, rr_arb2: 2-way round-robin grant plus pointer register.
- The scoreboard stays in the top level.

Test Plan:
- Reset: hold rst=0 with random inputs -> RegWrite=0, busy=0, claim_err=0, both readys respond per pointer=MEM.
- ALU only: alu_valid=1, addr=2, data=0xF -> alu_ready=1 the same cycle; next cycle RegWrite=1, WriteReg=2, WriteData=0xF.
- Both valid for 4 cycles, ALU addr=3, MEM addr=5 -> grants MEM, ALU, MEM, ALU; WriteReg sequence 5, 3, 5, 3 each one cycle later.
- Scoreboard/stall:
  - claim r7; chk_a1=7 -> stall=1.
  - ALU writes r7: stall stays 1 while RegWrite=1, then goes 0 the next cycle.
  - With REGWB_BYPASS_EN: stall=0 in the RegWrite cycle and fwd1_data=written value.
- Simultaneous claim and writeback of r4 -> busy[4] remains 1, claim_err=0. A second claim of r4 later -> claim_err=1 and it stays set.
- Assert rst mid-stream (both valid, busy nonzero) -> same edge: RegWrite=0, busy=0. After release the pointer restarts at MEM.
